// File: rtl/mips_pkg.sv
// Shared definitions for the 5-stage MIPS core pipeline.
//   NOP_INSTR        : encoding loaded into IF/ID on a redirect flush
//   CTRL_W           : width of the packed Decode control bundle
//   CTRL_*           : bit positions of the fields inside that bundle
//   RESET_PC_DEFAULT : PC loaded on reset unless overridden
package mips_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  localparam int CTRL_W = 10;

  // Control bundle layout; an all-zero bundle writes neither registers nor memory.
  localparam int CTRL_REGWRITE   = 0;
  localparam int CTRL_MEMTOREG   = 1;
  localparam int CTRL_MEMWRITE   = 2;
  localparam int CTRL_ALUCTL_LSB = 3;
  localparam int CTRL_ALUCTL_MSB = 7;
  localparam int CTRL_ALUSRC     = 8;
  localparam int CTRL_REGDST     = 9;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

endpackage

// File: rtl/pipe_reg.sv
// Generic pipeline register.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset, loads RST_VAL
//   en    : load d when high
//   clr   : synchronous clear to CLR_VAL, takes priority over en
//   d / q : data in / registered data out
module pipe_reg #(
  parameter int           W       = 32,
  parameter logic [W-1:0] RST_VAL = '0,
  parameter logic [W-1:0] CLR_VAL = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic         clr,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   q <= RST_VAL;
    else if (clr) q <= CLR_VAL;
    else if (en)  q <= d;
  end

endmodule

// File: rtl/pipe_front_regs.sv
// Front-end pipeline registers of the MIPS core: PC, IF/ID and ID/EX, with
// hazard-unit stall/flush controls, Decode-resolved PC redirection and two
// saturating performance counters.
//   CLK, RST                         : clock, async active-low reset
//   PR_StallF / PR_StallD / PR_FlushE: hazard controls
//   PR_PCSrcD, PR_JumpD, PR_PCBranchD, PR_PCJumpD : redirect request and targets
//   PR_InstrF                        : instruction fetched at PR_PCF
//   PR_CtrlD, PR_RD1D, PR_RD2D, PR_SignImmD, PR_RsD/RtD/RdD : Decode fields
//   PR_PCF                           : fetch PC
//   PR_InstrD, PR_PCPlus4D, PR_ValidD: IF/ID contents
//   PR_CtrlE ... PR_ValidE           : ID/EX contents
//   PR_StallCount, PR_BubbleCount    : performance counters
module pipe_front_regs
  import mips_pkg::*;
#(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    CTRL_W     = mips_pkg::CTRL_W,
  parameter logic [DATA_WIDTH-1:0] RESET_PC   = DATA_WIDTH'(mips_pkg::RESET_PC_DEFAULT),
  parameter int                    CNT_WIDTH  = 16
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  PR_StallF,
  input  logic                  PR_StallD,
  input  logic                  PR_FlushE,
  input  logic                  PR_PCSrcD,
  input  logic                  PR_JumpD,
  input  logic [DATA_WIDTH-1:0] PR_PCBranchD,
  input  logic [DATA_WIDTH-1:0] PR_PCJumpD,
  input  logic [DATA_WIDTH-1:0] PR_InstrF,
  input  logic [CTRL_W-1:0]     PR_CtrlD,
  input  logic [DATA_WIDTH-1:0] PR_RD1D,
  input  logic [DATA_WIDTH-1:0] PR_RD2D,
  input  logic [DATA_WIDTH-1:0] PR_SignImmD,
  input  logic [4:0]            PR_RsD,
  input  logic [4:0]            PR_RtD,
  input  logic [4:0]            PR_RdD,
  output logic [DATA_WIDTH-1:0] PR_PCF,
  output logic [DATA_WIDTH-1:0] PR_InstrD,
  output logic [DATA_WIDTH-1:0] PR_PCPlus4D,
  output logic                  PR_ValidD,
  output logic [CTRL_W-1:0]     PR_CtrlE,
  output logic [DATA_WIDTH-1:0] PR_RD1E,
  output logic [DATA_WIDTH-1:0] PR_RD2E,
  output logic [DATA_WIDTH-1:0] PR_SignImmE,
  output logic [4:0]            PR_RsE,
  output logic [4:0]            PR_RtE,
  output logic [4:0]            PR_RdE,
  output logic                  PR_ValidE,
  output logic [CNT_WIDTH-1:0]  PR_StallCount,
  output logic [CNT_WIDTH-1:0]  PR_BubbleCount
);

  localparam int IFID_W = 2 * DATA_WIDTH + 1;
  localparam int IDEX_W = CTRL_W + 3 * DATA_WIDTH + 15 + 1;

  localparam logic [IFID_W-1:0] IFID_FLUSH =
    {DATA_WIDTH'(NOP_INSTR), {(DATA_WIDTH + 1){1'b0}}};

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] c);
    return (&c) ? c : c + CNT_WIDTH'(1);
  endfunction

  logic                  redirect;
  logic                  flush_d;
  logic [DATA_WIDTH-1:0] pc_plus4;
  logic [DATA_WIDTH-1:0] pc_next;
  logic [IFID_W-1:0]     ifid_d, ifid_q;
  logic [IDEX_W-1:0]     idex_d, idex_q;

  assign redirect = PR_JumpD | PR_PCSrcD;
  // A stalled IF/ID keeps its contents, so the redirect flush only lands when not stalled.
  assign flush_d  = redirect & ~PR_StallD;
  assign pc_plus4 = PR_PCF + DATA_WIDTH'(4);

  // Jump outranks branch; while StallF is high the PC enable drops, so a
  // redirect presented during a stall is simply not taken.
  always_comb begin
    pc_next = pc_plus4;
    if (PR_JumpD)       pc_next = PR_PCJumpD;
    else if (PR_PCSrcD) pc_next = PR_PCBranchD;
  end

  // ---- Fetch: PC register ----
  pipe_reg #(
    .W       (DATA_WIDTH),
    .RST_VAL (RESET_PC),
    .CLR_VAL ('0)
  ) u_pc (
    .clk   (CLK),
    .rst_n (RST),
    .en    (~PR_StallF),
    .clr   (1'b0),
    .d     (pc_next),
    .q     (PR_PCF)
  );

  // ---- IF/ID boundary ----
  assign ifid_d = {PR_InstrF, pc_plus4, 1'b1};

  pipe_reg #(
    .W       (IFID_W),
    .RST_VAL ('0),
    .CLR_VAL (IFID_FLUSH)
  ) u_ifid (
    .clk   (CLK),
    .rst_n (RST),
    .en    (~PR_StallD),
    .clr   (flush_d),
    .d     (ifid_d),
    .q     (ifid_q)
  );

  assign {PR_InstrD, PR_PCPlus4D, PR_ValidD} = ifid_q;

  // ---- ID/EX boundary ----
  assign idex_d = {PR_CtrlD, PR_RD1D, PR_RD2D, PR_SignImmD,
                   PR_RsD, PR_RtD, PR_RdD, PR_ValidD};

  pipe_reg #(
    .W       (IDEX_W),
    .RST_VAL ('0),
    .CLR_VAL ('0)
  ) u_idex (
    .clk   (CLK),
    .rst_n (RST),
    .en    (1'b1),
    .clr   (PR_FlushE),
    .d     (idex_d),
    .q     (idex_q)
  );

  assign {PR_CtrlE, PR_RD1E, PR_RD2E, PR_SignImmE,
          PR_RsE, PR_RtE, PR_RdE, PR_ValidE} = idex_q;

  // ---- Performance counters ----
  // A cycle with both an ID/EX bubble and an IF/ID flush counts as one bubble.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      PR_StallCount  <= '0;
      PR_BubbleCount <= '0;
    end else begin
      if (PR_StallD)             PR_StallCount  <= sat_inc(PR_StallCount);
      if (PR_FlushE || flush_d)  PR_BubbleCount <= sat_inc(PR_BubbleCount);
    end
  end

endmodule

// File: tb/tb_pipe_front_regs.sv
// Bench for pipe_front_regs: directed vector table, counter saturation,
// asynchronous reset mid-stall, and randomized cycles against a reference model.
module tb_pipe_front_regs;

  localparam int DW   = 32;
  localparam int CW   = 10;
  localparam int CNTW = 4;
  localparam int CMAX = (1 << CNTW) - 1;

  logic          CLK = 1'b0;
  logic          RST = 1'b0;
  logic          PR_StallF, PR_StallD, PR_FlushE, PR_PCSrcD, PR_JumpD;
  logic [DW-1:0] PR_PCBranchD, PR_PCJumpD, PR_InstrF;
  logic [CW-1:0] PR_CtrlD;
  logic [DW-1:0] PR_RD1D, PR_RD2D, PR_SignImmD;
  logic [4:0]    PR_RsD, PR_RtD, PR_RdD;
  logic [DW-1:0] PR_PCF, PR_InstrD, PR_PCPlus4D;
  logic          PR_ValidD, PR_ValidE;
  logic [CW-1:0] PR_CtrlE;
  logic [DW-1:0] PR_RD1E, PR_RD2E, PR_SignImmE;
  logic [4:0]    PR_RsE, PR_RtE, PR_RdE;
  logic [CNTW-1:0] PR_StallCount, PR_BubbleCount;

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  pipe_front_regs #(
    .DATA_WIDTH (DW),
    .CTRL_W     (CW),
    .RESET_PC   (32'h0),
    .CNT_WIDTH  (CNTW)
  ) dut (
    .CLK(CLK), .RST(RST),
    .PR_StallF(PR_StallF), .PR_StallD(PR_StallD), .PR_FlushE(PR_FlushE),
    .PR_PCSrcD(PR_PCSrcD), .PR_JumpD(PR_JumpD),
    .PR_PCBranchD(PR_PCBranchD), .PR_PCJumpD(PR_PCJumpD), .PR_InstrF(PR_InstrF),
    .PR_CtrlD(PR_CtrlD), .PR_RD1D(PR_RD1D), .PR_RD2D(PR_RD2D), .PR_SignImmD(PR_SignImmD),
    .PR_RsD(PR_RsD), .PR_RtD(PR_RtD), .PR_RdD(PR_RdD),
    .PR_PCF(PR_PCF), .PR_InstrD(PR_InstrD), .PR_PCPlus4D(PR_PCPlus4D), .PR_ValidD(PR_ValidD),
    .PR_CtrlE(PR_CtrlE), .PR_RD1E(PR_RD1E), .PR_RD2E(PR_RD2E), .PR_SignImmE(PR_SignImmE),
    .PR_RsE(PR_RsE), .PR_RtE(PR_RtE), .PR_RdE(PR_RdE), .PR_ValidE(PR_ValidE),
    .PR_StallCount(PR_StallCount), .PR_BubbleCount(PR_BubbleCount)
  );

  // Reference model state
  logic [DW-1:0] m_pc, m_instrD, m_pc4D, m_rd1E, m_rd2E, m_immE;
  logic          m_vD, m_vE;
  logic [CW-1:0] m_ctrlE;
  logic [4:0]    m_rsE, m_rtE, m_rdE;
  int            m_sc, m_bc;

  task automatic model_reset();
    m_pc = 32'h0; m_instrD = '0; m_pc4D = '0; m_vD = 1'b0;
    m_ctrlE = '0; m_rd1E = '0; m_rd2E = '0; m_immE = '0;
    m_rsE = '0; m_rtE = '0; m_rdE = '0; m_vE = 1'b0;
    m_sc = 0; m_bc = 0;
  endtask

  // One clock of the pipeline's rules, applied to the inputs about to be sampled.
  task automatic model_update();
    bit redir_taken;
    redir_taken = (PR_JumpD || PR_PCSrcD) && !PR_StallD;
    if (PR_StallD && m_sc < CMAX) m_sc++;
    if ((PR_FlushE || redir_taken) && m_bc < CMAX) m_bc++;
    if (PR_FlushE) begin
      m_ctrlE = '0; m_rd1E = '0; m_rd2E = '0; m_immE = '0;
      m_rsE = '0; m_rtE = '0; m_rdE = '0; m_vE = 1'b0;
    end else begin
      m_ctrlE = PR_CtrlD; m_rd1E = PR_RD1D; m_rd2E = PR_RD2D; m_immE = PR_SignImmD;
      m_rsE = PR_RsD; m_rtE = PR_RtD; m_rdE = PR_RdD; m_vE = m_vD;
    end
    if (!PR_StallD) begin
      if (PR_JumpD || PR_PCSrcD) begin
        m_instrD = 32'h0; m_pc4D = '0; m_vD = 1'b0;
      end else begin
        m_instrD = PR_InstrF; m_pc4D = m_pc + 32'd4; m_vD = 1'b1;
      end
    end
    if (!PR_StallF) begin
      if (PR_JumpD)       m_pc = PR_PCJumpD;
      else if (PR_PCSrcD) m_pc = PR_PCBranchD;
      else                m_pc = m_pc + 32'd4;
    end
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".PCF"},      PR_PCF,         m_pc);
    chk({tag, ".InstrD"},   PR_InstrD,      m_instrD);
    chk({tag, ".PCPlus4D"}, PR_PCPlus4D,    m_pc4D);
    chk({tag, ".ValidD"},   PR_ValidD,      m_vD);
    chk({tag, ".CtrlE"},    PR_CtrlE,       m_ctrlE);
    chk({tag, ".RD1E"},     PR_RD1E,        m_rd1E);
    chk({tag, ".RD2E"},     PR_RD2E,        m_rd2E);
    chk({tag, ".SignImmE"}, PR_SignImmE,    m_immE);
    chk({tag, ".RsE"},      PR_RsE,         m_rsE);
    chk({tag, ".RtE"},      PR_RtE,         m_rtE);
    chk({tag, ".RdE"},      PR_RdE,         m_rdE);
    chk({tag, ".ValidE"},   PR_ValidE,      m_vE);
    chk({tag, ".StallCnt"}, PR_StallCount,  m_sc);
    chk({tag, ".BubbleCnt"},PR_BubbleCount, m_bc);
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, ".PCF"},      PR_PCF,         32'h0);
    chk({tag, ".InstrD"},   PR_InstrD,      32'h0);
    chk({tag, ".PCPlus4D"}, PR_PCPlus4D,    32'h0);
    chk({tag, ".ValidD"},   PR_ValidD,      1'b0);
    chk({tag, ".CtrlE"},    PR_CtrlE,       '0);
    chk({tag, ".RD1E"},     PR_RD1E,        '0);
    chk({tag, ".ValidE"},   PR_ValidE,      1'b0);
    chk({tag, ".StallCnt"}, PR_StallCount,  '0);
    chk({tag, ".BubbleCnt"},PR_BubbleCount, '0);
  endtask

  task automatic rand_operands();
    PR_RD1D = $urandom; PR_RD2D = $urandom; PR_SignImmD = $urandom;
    PR_RsD = 5'($urandom); PR_RtD = 5'($urandom); PR_RdD = 5'($urandom);
  endtask

  task automatic step();
    model_update();
    @(posedge CLK);
    #1;
  endtask

  typedef struct {
    logic sf, sd, fe, bsrc, jmp;
    logic [31:0] btgt, jtgt, instr;
    logic [9:0]  ctrl;
    logic [31:0] x_pc, x_instr, x_pc4;
    logic        x_vd, x_ve;
    logic [9:0]  x_ctrl;
    int          x_sc, x_bc;
  } vec_t;

  vec_t tbl[7];

  initial begin
    // sf sd fe bsrc jmp  btgt   jtgt    instr          ctrl  | pc      instrD         pc4     vd ve ctrlE  sc bc
    tbl[0] = '{0,0,0,0,0, 32'h0,  32'h0,   32'h2008_0005, 10'h2A5, 32'h4,   32'h2008_0005, 32'h4,   1,0, 10'h2A5, 0,0};
    tbl[1] = '{0,0,0,0,0, 32'h0,  32'h0,   32'h2008_0005, 10'h2A5, 32'h8,   32'h2008_0005, 32'h8,   1,1, 10'h2A5, 0,0};
    tbl[2] = '{1,1,1,0,0, 32'h0,  32'h0,   32'h2008_0005, 10'h2A5, 32'h8,   32'h2008_0005, 32'h8,   1,0, 10'h000, 1,1};
    tbl[3] = '{0,0,0,1,0, 32'h40, 32'h0,   32'h1111_2222, 10'h2A5, 32'h40,  32'h0,         32'h0,   0,1, 10'h2A5, 1,2};
    tbl[4] = '{0,0,0,1,1, 32'h40, 32'h100, 32'h3333_4444, 10'h2A5, 32'h100, 32'h0,         32'h0,   0,0, 10'h2A5, 1,3};
    tbl[5] = '{1,1,1,1,0, 32'h40, 32'h0,   32'h5555_6666, 10'h2A5, 32'h100, 32'h0,         32'h0,   0,0, 10'h000, 2,4};
    tbl[6] = '{0,0,0,0,0, 32'h0,  32'h0,   32'hAABB_CCDD, 10'h2A5, 32'h104, 32'hAABB_CCDD, 32'h104, 1,0, 10'h2A5, 2,4};

    PR_StallF = 0; PR_StallD = 0; PR_FlushE = 0; PR_PCSrcD = 0; PR_JumpD = 0;
    PR_PCBranchD = '0; PR_PCJumpD = '0; PR_InstrF = '0; PR_CtrlD = '0;
    rand_operands();
    model_reset();

    #12;
    check_reset_state("reset");
    RST = 1'b1;

    for (int i = 0; i < 7; i++) begin
      PR_StallF = tbl[i].sf; PR_StallD = tbl[i].sd; PR_FlushE = tbl[i].fe;
      PR_PCSrcD = tbl[i].bsrc; PR_JumpD = tbl[i].jmp;
      PR_PCBranchD = tbl[i].btgt; PR_PCJumpD = tbl[i].jtgt;
      PR_InstrF = tbl[i].instr; PR_CtrlD = tbl[i].ctrl;
      rand_operands();
      step();
      chk($sformatf("vec%0d.PCF", i),       PR_PCF,         tbl[i].x_pc);
      chk($sformatf("vec%0d.InstrD", i),    PR_InstrD,      tbl[i].x_instr);
      chk($sformatf("vec%0d.PCPlus4D", i),  PR_PCPlus4D,    tbl[i].x_pc4);
      chk($sformatf("vec%0d.ValidD", i),    PR_ValidD,      tbl[i].x_vd);
      chk($sformatf("vec%0d.ValidE", i),    PR_ValidE,      tbl[i].x_ve);
      chk($sformatf("vec%0d.CtrlE", i),     PR_CtrlE,       tbl[i].x_ctrl);
      chk($sformatf("vec%0d.StallCnt", i),  PR_StallCount,  tbl[i].x_sc);
      chk($sformatf("vec%0d.BubbleCnt", i), PR_BubbleCount, tbl[i].x_bc);
      check_model($sformatf("vec%0d.model", i));
    end

    // 20 stall cycles: stall counter must pin at all-ones, PC must hold.
    PR_StallF = 1; PR_StallD = 1; PR_FlushE = 0; PR_PCSrcD = 0; PR_JumpD = 0;
    for (int i = 0; i < 20; i++) begin
      PR_InstrF = $urandom;
      rand_operands();
      step();
      check_model("sat");
    end
    chk("sat.StallCnt", PR_StallCount, 4'hF);
    chk("sat.PCF",      PR_PCF,        32'h104);

    // Reset asserted mid-stall, between clock edges.
    #1 RST = 1'b0;
    #1 check_reset_state("async_rst");
    model_reset();
    #1 RST = 1'b1;

    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < 150; i++) begin
        PR_StallF    = ($urandom_range(0, 4) == 0);
        PR_StallD    = ($urandom_range(0, 4) == 0);
        PR_FlushE    = ($urandom_range(0, 4) == 0);
        PR_PCSrcD    = ($urandom_range(0, 5) == 0);
        PR_JumpD     = ($urandom_range(0, 7) == 0);
        PR_PCBranchD = $urandom;
        PR_PCJumpD   = $urandom;
        PR_InstrF    = $urandom;
        PR_CtrlD     = 10'($urandom);
        rand_operands();
        step();
        check_model($sformatf("rand%0d.%0d", r, i));
      end
      #1 RST = 1'b0;
      #1 check_reset_state($sformatf("rand_rst%0d", r));
      model_reset();
      #1 RST = 1'b1;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_front_regs.md
# pipe_front_regs

Front-end pipeline register block of the 5-stage MIPS core. It holds the PC, the IF/ID register and the ID/EX register, and applies the StallF, StallD and FlushE controls produced by the hazard unit. It also applies PC redirection for taken branches and jumps resolved in Decode. Two saturating performance counters track stall cycles and inserted bubbles. It sits between instruction memory and the register file on one side and the Execute stage on the other.

## Interface
Parameters:
- DATA_WIDTH, 32: datapath, PC and instruction width.
- CTRL_W, 10: width of the packed Decode control bundle. An all-zero bundle means no register write and no memory write.
- RESET_PC, 32'h0000_0000: PC value loaded on reset.
- CNT_WIDTH, 16: width of each performance counter.

Ports (name, direction, width, meaning):
- CLK  in  1  core clock; all state updates on the rising edge.
- RST  in  1  asynchronous, active-low reset.
- PR_StallF  in  1  hold the PC.
- PR_StallD  in  1  hold the IF/ID register.
- PR_FlushE  in  1  load a bubble into the ID/EX register.
- PR_PCSrcD  in  1  branch resolved taken in Decode.
- PR_JumpD  in  1  jump decoded in Decode.
- PR_PCBranchD  in  DATA_WIDTH  branch target.
- PR_PCJumpD  in  DATA_WIDTH  jump target.
- PR_InstrF  in  DATA_WIDTH  instruction read from instruction memory at PR_PCF.
- PR_CtrlD  in  CTRL_W  Decode control bundle.
- PR_RD1D, PR_RD2D, PR_SignImmD  in  DATA_WIDTH  Decode operands.
- PR_RsD, PR_RtD, PR_RdD  in  5  Decode register specifiers.
- PR_PCF  out  DATA_WIDTH  fetch PC.
- PR_InstrD, PR_PCPlus4D  out  DATA_WIDTH  IF/ID contents.
- PR_ValidD  out  1  IF/ID holds a real instruction.
- PR_CtrlE  out  CTRL_W  ID/EX control.
- PR_RD1E, PR_RD2E, PR_SignImmE  out  DATA_WIDTH  ID/EX operands.
- PR_RsE, PR_RtE, PR_RdE  out  5  ID/EX specifiers.
- PR_ValidE  out  1  ID/EX holds a real instruction.
- PR_StallCount, PR_BubbleCount  out  CNT_WIDTH  performance counters.

## Operation
- **PC.**
  - If PR_StallF is 1, hold.
  - Else if PR_JumpD, load PR_PCJumpD.
  - Else if PR_PCSrcD, load PR_PCBranchD.
  - Else load PR_PCF+4, wrapping modulo 2^DATA_WIDTH. Jump has priority over branch.
- **IF/ID.**
  - If PR_StallD is 1, hold, including PR_ValidD. Stall has priority over the redirect flush.
  - Else if PR_JumpD or PR_PCSrcD, flush: InstrD=NOP (32'h0), PCPlus4D=0, ValidD=0.
  - Else load InstrF, PCF+4, and ValidD=1.
- **ID/EX.**
  - If PR_FlushE, clear every field to 0; CtrlE=0 and ValidE=0.
  - Else load all Decode fields, with ValidE=PR_ValidD.
  - This register has no stall input.
- **PR_StallCount.** Increments in each cycle with PR_StallD=1. Saturates at all-ones.
- **PR_BubbleCount.** Increments by 1 in each cycle where FlushE is applied or an IF/ID redirect flush is applied. It adds 1, not 2, when both happen in the same cycle. Saturates at all-ones.
- **Stall with redirect.** PR_StallF together with PR_PCSrcD or PR_JumpD means the branch operands are not ready. The PC holds, the redirect is ignored, and the hazard unit re-presents it next cycle.

## Timing
- **Latency.** One cycle per register: PR_PCF to PR_InstrD is 1 cycle, and PR_InstrD to PR_CtrlE is 1 cycle.
- **Redirect.** A redirect asserted in cycle N yields PR_PCF = target at cycle N+1, and a NOP in IF/ID at N+1.
- **Reset (asynchronous, RST low).**
  - PR_PCF=RESET_PC.
  - Every other output is 0, including both Valid bits and both counters.
  - Asserting reset mid-stall discards all held state immediately.
- **After reset release.** The first rising edge loads IF/ID from RESET_PC, with PR_PCF advancing to RESET_PC+4. ValidE becomes 1 on the second edge.

## Structure
- Shared package `mips_pkg` holds:
  - NOP_INSTR = 32'h0;
  - CTRL_W and the control-bundle bit positions (RegWrite, MemtoReg, MemWrite, ALUControl, ALUSrc, RegDst);
  - the RESET_PC default.
- Sub-module `pipe_reg`: a parameterized-width register with async active-low reset, enable, synchronous clear and clear value. IF/ID and ID/EX are each instances of `pipe_reg`. The counters are a local saturating-increment block.

## Test plan
- **Reset then free-run:** RST low then high, InstrF=32'h2008_0005, no stalls → PR_PCF sequence 0,4,8; cycle 1 InstrD=32'h2008_0005, PCPlus4D=4, ValidD=1.
- **Load-use stall:** StallF=StallD=FlushE=1 for one cycle → PR_PCF and PR_InstrD unchanged, CtrlE=0, ValidE=0, StallCount=1, BubbleCount=1.
- **Taken branch:** PCSrcD=1, PCBranchD=32'h40 → next cycle PR_PCF=32'h40, InstrD=0, ValidD=0, BubbleCount +1.
- **Jump and branch together:** PCJumpD=32'h100, PCBranchD=32'h40 → PR_PCF=32'h100.
- **Branch stall:** StallF=StallD=FlushE=1 with PCSrcD=1 → PC holds, IF/ID holds, no redirect.
- **Saturation and reset mid-stall:** CNT_WIDTH=4 with 20 stall cycles → StallCount=15. Then RST low mid-stall → all outputs return to reset values without waiting for a clock edge.
